// File: rtl/uni_counter_sequencer.sv
// Round-robin sequencer that shares one 4-bit universal counter between two requesters.
// Optional abort port/flag when UNI_SEQ_ABORT_EN is defined.
module uni_counter_sequencer #(
    parameter int STEP_W = 8
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [1:0]          req_mode,
    input  logic [1:0]          req_incr,
    input  logic [1:0]          req_clr_first,
    input  logic [2*STEP_W-1:0] req_steps,
    input  logic [3:0]          cnt_value,
    output logic                cnt_mode,
    output logic                cnt_clear,
    output logic                cnt_incr,
    output logic                cnt_pause,
    output logic                busy,
    output logic                done,
    output logic                done_id,
    output logic [3:0]          done_value,
    output logic [1:0]          state_dbg
`ifdef UNI_SEQ_ABORT_EN
    ,
    input  logic                abort,
    output logic                done_aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              rr;
    logic              winner;
    logic              handshake;
    logic              abort_hit;
    logic [STEP_W-1:0] win_steps;
    logic [STEP_W-1:0] remaining;
    logic              job_mode;
    logic              job_incr;
    logic              job_id;
    logic              nxt_id;
    logic              clr_q;
    logic              pause_q;
    logic              busy_q;
    logic              done_q;
    logic              done_id_q;
    logic [3:0]        done_value_q;

    // Handshake: a job transfers on a clock edge where req_valid[i] & req_ready[i];
    // ready is only offered in IDLE, to a single winner, never during clear.
    always_comb begin
        winner    = (req_valid == 2'b11) ? rr : req_valid[1];
        req_ready = 2'b00;
        if (state == IDLE && !clear && req_valid != 2'b00)
            req_ready[winner] = 1'b1;
        handshake = |(req_valid & req_ready);
        win_steps = winner ? req_steps[2*STEP_W-1:STEP_W] : req_steps[STEP_W-1:0];
        nxt_id    = handshake ? winner : job_id;
`ifdef UNI_SEQ_ABORT_EN
        abort_hit = abort && (state == CLR || state == RUN);
`else
        abort_hit = 1'b0;
`endif
        state_nxt = state;
        case (state)
            IDLE: if (handshake)
                      state_nxt = req_clr_first[winner] ? CLR :
                                  (win_steps != '0) ? RUN : DONE;
            CLR:  state_nxt = (abort_hit || remaining == '0) ? DONE : RUN;
            RUN:  if (abort_hit || remaining == STEP_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            rr           <= 1'b0;
            remaining    <= '0;
            job_mode     <= 1'b0;
            job_incr     <= 1'b0;
            job_id       <= 1'b0;
            clr_q        <= 1'b0;
            pause_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
            done_value_q <= 4'd0;
`ifdef UNI_SEQ_ABORT_EN
            done_aborted <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (handshake) begin
                job_mode  <= req_mode[winner];
                job_incr  <= req_incr[winner];
                job_id    <= winner;
                remaining <= win_steps;
                rr        <= ~winner;
            end else if (state == RUN) begin
                remaining <= remaining - STEP_W'(1);
            end
            // Control outputs are registered from the next state so they line up with it.
            clr_q   <= (state_nxt == CLR);
            pause_q <= (state_nxt != RUN);
            busy_q  <= (state_nxt != IDLE);
            done_q  <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                done_id_q    <= nxt_id;
`ifdef UNI_SEQ_ABORT_EN
                done_aborted <= abort_hit;
`endif
            end
            if (state == DONE)
                done_value_q <= cnt_value;
        end
    end

    // In DONE the live counter value already includes the final RUN edge.
    assign done_value = (state == DONE) ? cnt_value : done_value_q;
    assign cnt_clear  = clear | clr_q;
    assign cnt_pause  = pause_q;
    assign cnt_mode   = job_mode;
    assign cnt_incr   = job_incr;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_id    = done_id_q;
    assign state_dbg  = state;

endmodule

// File: tb/tb_uni_counter_sequencer.sv
// Bench for uni_counter_sequencer: behavioural counter, arithmetic reference for
// final values and latency, directed plan cases plus randomized jobs.
module tb_uni_counter_sequencer;

    localparam int STEP_W = 8;

    logic                clk = 1'b0;
    logic                clear;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [1:0]          req_mode;
    logic [1:0]          req_incr;
    logic [1:0]          req_clr_first;
    logic [2*STEP_W-1:0] req_steps;
    logic [3:0]          cnt_value;
    logic                cnt_mode;
    logic                cnt_clear;
    logic                cnt_incr;
    logic                cnt_pause;
    logic                busy;
    logic                done;
    logic                done_id;
    logic [3:0]          done_value;
    logic [1:0]          state_dbg;
`ifdef UNI_SEQ_ABORT_EN
    logic                abort;
    logic                done_aborted;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] exp_q[$];
    logic [3:0] cv;

    always #5 clk = ~clk;

    uni_counter_sequencer #(.STEP_W(STEP_W)) dut (
        .clk(clk), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_incr(req_incr), .req_clr_first(req_clr_first),
        .req_steps(req_steps), .cnt_value(cnt_value),
        .cnt_mode(cnt_mode), .cnt_clear(cnt_clear), .cnt_incr(cnt_incr), .cnt_pause(cnt_pause),
        .busy(busy), .done(done), .done_id(done_id), .done_value(done_value),
        .state_dbg(state_dbg)
`ifdef UNI_SEQ_ABORT_EN
        , .abort(abort), .done_aborted(done_aborted)
`endif
    );

    // Behavioural universal counter driven by the sequencer.
    always @(posedge clk) begin
        if (cnt_clear)
            cv <= 4'd0;
        else if (!cnt_pause) begin
            if (cnt_mode)
                cv <= cnt_incr ? ((cv >= 4'd9) ? 4'd0 : cv + 4'd1) : ((cv == 4'd0) ? 4'd9 : cv - 4'd1);
            else
                cv <= cnt_incr ? cv + 4'd1 : cv - 4'd1;
        end
    end
    assign cnt_value = cv;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_value(input int start, input bit mode, input bit incr, input int k);
        int m;
        m = mode ? 10 : 16;
        return incr ? (start + k) % m : ((start - (k % m)) + m) % m;
    endfunction

    task automatic run_job(input int id, input bit mode, input bit incr, input bit clrf,
                           input int steps, input int abort_at);
        int start, k, exp_val, exp_lat, n_run, lat;
        bit got, aborted;
        @(negedge clk);
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        req_mode[id] = mode;
        req_incr[id] = incr;
        req_clr_first[id] = clrf;
        req_steps[id*STEP_W +: STEP_W] = STEP_W'(steps);
        #1;
        for (int i = 0; i < 50 && !req_ready[id]; i++) begin
            @(negedge clk);
            #1;
        end
        check("grant", int'(req_ready[id]), 1);
        start   = clrf ? 0 : int'(cv);
        aborted = (abort_at > 0) && (abort_at <= steps);
        k       = aborted ? abort_at : steps;
        exp_val = ref_value(start, mode, incr, k);
        exp_q.push_back(4'(exp_val));
        exp_lat = int'(clrf) + k + 1;
        @(negedge clk);
        req_valid[id] = 1'b0;
        n_run = 0;
        got   = 1'b0;
        lat   = 0;
        for (int c = 1; c <= 600 && !got; c++) begin
            if (!cnt_pause) begin
                n_run++;
                if (n_run == 1) begin
                    check("cnt_mode", int'(cnt_mode), int'(mode));
                    check("cnt_incr", int'(cnt_incr), int'(incr));
                end
            end
`ifdef UNI_SEQ_ABORT_EN
            abort = !cnt_pause && (n_run == abort_at);
`endif
            if (done) begin
                got = 1'b1;
                lat = c;
            end else
                @(negedge clk);
        end
        check("done_seen", int'(got), 1);
        check("latency", lat, exp_lat);
        check("run_cycles", n_run, k);
        check("done_id", int'(done_id), id);
        check("done_value", int'(done_value), int'(exp_q.pop_front()));
`ifdef UNI_SEQ_ABORT_EN
        check("done_aborted", int'(done_aborted), int'(aborted));
`endif
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("back_idle", int'(busy), 0);
        check("value_hold", int'(done_value), exp_val);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, grants, exp_g, id, steps, ab;
        bit saw_done, both, mode, incr, clrf;
        clear = 1'b1;
        req_valid = 2'b00;
        req_mode = 2'b00;
        req_incr = 2'b00;
        req_clr_first = 2'b00;
        req_steps = '0;
`ifdef UNI_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_ready", int'(req_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_done_id", int'(done_id), 0);
        check("rst_done_value", int'(done_value), 0);
        check("rst_pause", int'(cnt_pause), 1);
        check("rst_cnt_clear", int'(cnt_clear), 1);
        check("rst_mode", int'(cnt_mode), 0);
        check("rst_incr", int'(cnt_incr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_state", int'(state_dbg), 0);
`ifdef UNI_SEQ_ABORT_EN
        check("rst_aborted", int'(done_aborted), 0);
`endif
        clear = 1'b0;

        // Directed plan jobs.
        run_job(0, 1'b1, 1'b1, 1'b1, 12, 0);
        run_job(1, 1'b0, 1'b1, 1'b1, 18, 0);

        // Clear on the third RUN cycle of a 10-step job from requester 0.
        @(negedge clk);
        req_valid = 2'b01;
        req_mode[0] = 1'b0;
        req_incr[0] = 1'b1;
        req_clr_first[0] = 1'b0;
        req_steps[STEP_W-1:0] = STEP_W'(10);
        @(negedge clk);
        req_valid = 2'b00;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (!cnt_pause) n++;
            if (n < 3) @(negedge clk);
        end
        check("run3_reached", n, 3);
        clear = 1'b1;
        #1;
        check("clear_comb", int'(cnt_clear), 1);
        req_valid = 2'b11;
        req_mode = 2'b00;
        req_incr = 2'b11;
        req_clr_first = 2'b00;
        req_steps = {STEP_W'(1), STEP_W'(1)};
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            saw_done |= done;
        end
        #1;
        check("abandon_no_done", int'(saw_done), 0);
        check("abandon_busy", int'(busy), 0);
        check("abandon_state", int'(state_dbg), 0);
        check("abandon_pause", int'(cnt_pause), 1);
        check("abandon_value", int'(done_value), 0);
        check("abandon_cnt_clear", int'(cnt_clear), 1);
        check("ready_in_clear", int'(req_ready), 0);

        // Both requesters held valid: grants must alternate starting at 0.
        clear = 1'b0;
        grants = 0;
        exp_g = 0;
        both = 1'b0;
        for (int c = 0; c < 80 && grants < 4; c++) begin
            #1;
            if (req_ready == 2'b11) both = 1'b1;
            if (req_ready != 2'b00) begin
                check("rr_grant", int'(req_ready[1]), exp_g);
                exp_g ^= 1;
                grants++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        check("rr_grants", grants, 4);
        check("ready_onehot", int'(both), 0);
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        check("rr_idle", int'(busy), 0);

        // Zero-step job leaves the counter at 5.
        run_job(1, 1'b0, 1'b1, 1'b1, 5, 0);
        run_job(0, 1'b0, 1'b1, 1'b0, 0, 0);

        for (int j = 0; j < 30; j++) begin
            id    = $urandom_range(0, 1);
            mode  = 1'($urandom_range(0, 1));
            incr  = 1'($urandom_range(0, 1));
            clrf  = 1'($urandom_range(0, 1));
            steps = $urandom_range(0, 20);
            if (mode && cv > 4'd9) clrf = 1'b1;
            ab = 0;
`ifdef UNI_SEQ_ABORT_EN
            if (steps > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, steps);
`endif
            run_job(id, mode, incr, clrf, steps, ab);
        end

`ifdef UNI_SEQ_ABORT_EN
        run_job(0, 1'b0, 1'b1, 1'b1, 10, 4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uni_counter_sequencer.md
Name: uni_counter_sequencer

Overview:
- Sequencer and arbiter that shares one 4-bit universal counter (hex/decimal, up/down, clear, pause) between two requesters.
- Each requester submits a job: count mode, direction, step count, and an optional clear-first.
- The block grants requesters round-robin, drives the counter's mode/clear/incr/pause controls for exactly the requested number of count cycles, then reports the final counter value.
- Sits between the requester logic and the counter instance.

Parameters:
STEP_W, 8, width of the step-count field; max job length is 2^STEP_W-1 count cycles

Ports:
clk  in  1  system clock, all logic on posedge
clear  in  1  synchronous active-high reset
req_valid  in  2  per-requester job valid; bit i = requester i
req_ready  out  2  per-requester accept; at most one bit high
req_mode  in  2  per-requester mode; 1 = decimal, 0 = hex
req_incr  in  2  per-requester direction; 1 = up, 0 = down
req_clr_first  in  2  per-requester flag: clear the counter before counting
req_steps  in  2*STEP_W  per-requester step count; requester i at bits [i*STEP_W +: STEP_W]
cnt_value  in  4  current counter output
cnt_mode  out  1  to counter mode input
cnt_clear  out  1  to counter clear input
cnt_incr  out  1  to counter incr input
cnt_pause  out  1  to counter pause input
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at job completion
done_id  out  1  requester index of the completed job
done_value  out  4  counter value at completion

Behaviour:
- Reset values (while clear=1): state=IDLE, rr pointer=0, req_ready=0, done=0, done_id=0, done_value=0, cnt_pause=1, cnt_clear=1, cnt_mode=0, cnt_incr=0, busy=0.
- cnt_clear is asserted combinationally from clear, so the counter resets together with the sequencer.
- States: IDLE, CLR, RUN, DONE.
- IDLE:
  - cnt_pause=1.
  - Winner is the requester with valid=1. If both are valid, the winner is the rr pointer's requester.
  - req_ready[winner]=1 combinationally in IDLE only. Handshake = valid & ready in the same cycle.
  - On handshake: latch mode, incr, steps, clr_first and id; set rr pointer = ~winner.
  - Next state: CLR if clr_first; otherwise RUN if steps != 0; otherwise DONE.
- CLR:
  - cnt_clear=1, cnt_pause=1, for one cycle.
  - Next state: RUN if steps != 0; otherwise DONE.
- RUN:
  - cnt_pause=0; cnt_mode and cnt_incr come from the latched job.
  - A remaining-step register starts at steps and decrements each cycle.
  - When remaining==1, next state is DONE. The counter therefore sees exactly `steps` unpaused edges.
- DONE:
  - cnt_pause=1, done=1, done_id=latched id, done_value=cnt_value (already reflects the last RUN edge).
  - Next state: IDLE.
  - done_value and done_id hold until the next DONE.
- Job latency: handshake edge + (clr_first ? 1 : 0) + steps + 1 cycles to the done pulse.
- No new job is accepted until IDLE; the back-to-back minimum is one IDLE cycle between jobs.
- A request withdrawn before its handshake is ignored; no state change.
- steps=0 with clr_first=0: the counter is untouched, DONE next cycle, done_value = current counter value.
- Counter wrap-around (9->0 decimal, 15->0 hex, down-count wraps) is the counter's behaviour. The sequencer neither checks nor alters it.
- clear mid-job: the job is abandoned, no done pulse, every output returns to its reset value, and the rr pointer returns to 0.

Optional Feature:
- Macro: UNI_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output done_aborted (1 bit, reset 0).
  - abort=1 in CLR or RUN: next state is DONE, counting stops (cnt_pause=1 from the next cycle), and done_aborted=1 with the done pulse.
  - abort is ignored in IDLE and DONE.
  - done_aborted=0 on normal completion.
- When undefined: neither port exists and jobs always run to completion.

Test Plan:
- clear 2 cycles, then req0: mode=1, incr=1, clr_first=1, steps=12 -> ready0 on 1 cycle; done at handshake+14; done_id=0; done_value=2.
- req1: mode=0, incr=1, clr_first=1, steps=18 -> done_value=2; exactly 18 cycles with cnt_pause=0.
- req0 and req1 both held valid from reset, each steps=1 -> grants in order 0, 1, 0, 1; ready never high for both bits together.
- Job with clr_first=0, steps=0, counter at 5 -> no cnt_pause=0 cycle; done next cycle; done_value=5.
- clear asserted on the 3rd RUN cycle of a 10-step job -> no done pulse; state IDLE; cnt_clear=1 while clear is high; the next job starts normally.
- (UNI_SEQ_ABORT_EN) abort during the 4th RUN cycle of a 10-step job -> done next cycle, done_aborted=1; counter advanced 4 steps.
